// File: rtl/sdram_lowpower_ctrl.sv
// Low-power sequencer: precharge-all, then self-refresh or precharge power-down,
// hold while requested, exit with recovery delay. Outputs are registered from the next state.
module sdram_lowpower_ctrl #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BA_W      = 2,
    parameter int unsigned T_RP      = 2,
    parameter int unsigned T_CKE_MIN = 4,
    parameter int unsigned T_XSR     = 8,
    parameter int unsigned T_XP      = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sdram_init,
    input  logic              lp_req,
    input  logic              lp_mode,
    output logic              lp_ack,
    output logic              lp_done,
    output logic              busy,
    output logic [CNT_W-1:0]  lp_cycles,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;

    localparam int unsigned T_MAX0 = (T_RP > T_XSR) ? T_RP : T_XSR;
    localparam int unsigned T_MAX  = (T_MAX0 > T_XP) ? T_MAX0 : T_XP;
    localparam int unsigned WAIT_W = $clog2(T_MAX + 1);

    localparam logic [ADDR_W-1:0] A10_MASK  = ADDR_W'(1) << 10;
    localparam logic [CNT_W-1:0]  CKE_MIN_C = CNT_W'(T_CKE_MIN);
    localparam logic [WAIT_W-1:0] TRP_LOAD  = WAIT_W'((T_RP > 1) ? (T_RP - 2) : 0);
    localparam logic [WAIT_W-1:0] XSR_LOAD  = WAIT_W'(T_XSR - 1);
    localparam logic [WAIT_W-1:0] XP_LOAD   = WAIT_W'(T_XP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_TRP, S_ENTER, S_HOLD, S_EXIT, S_DONE
    } state_t;

    state_t              r_state;
    logic                r_mode;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_lp_cycles;
    logic                r_ack;
    logic                r_done;
    logic                r_busy;
    logic                r_cke;
    logic [3:0]          r_cmd;
    logic [ADDR_W-1:0]   r_addr;

    logic [CNT_W-1:0]    w_cnt_inc;

    // Residency counter saturates instead of wrapping
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_wait      <= '0;
            r_cnt       <= '0;
            r_lp_cycles <= '0;
            r_ack       <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cke       <= 1'b1;
            r_cmd       <= CMD_NOP;
            r_addr      <= '0;
        end else begin
            r_cmd  <= CMD_NOP;
            r_addr <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lp_req && sdram_init) begin
                        r_mode  <= lp_mode;
                        r_state <= S_PRE;
                        r_cmd   <= CMD_PRE;
                        r_addr  <= A10_MASK;
                        r_busy  <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (T_RP == 1) begin
                        r_state <= S_ENTER;
                        r_cke   <= 1'b0;
                        r_cmd   <= r_mode ? CMD_NOP : CMD_AR;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_state <= S_TRP;
                        r_wait  <= TRP_LOAD;
                    end
                end
                S_TRP: begin
                    if (r_wait == '0) begin
                        r_state <= S_ENTER;
                        r_cke   <= 1'b0;
                        r_cmd   <= r_mode ? CMD_NOP : CMD_AR;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_ENTER: begin
                    r_state <= S_HOLD;
                    r_ack   <= 1'b1;
                    r_cnt   <= w_cnt_inc;
                end
                S_HOLD: begin
                    // Release only once the CKE-low minimum has been honoured
                    if (!lp_req && (r_cnt >= CKE_MIN_C)) begin
                        r_state     <= S_EXIT;
                        r_cke       <= 1'b1;
                        r_ack       <= 1'b0;
                        r_lp_cycles <= r_cnt;
                        r_wait      <= r_mode ? XP_LOAD : XSR_LOAD;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_EXIT: begin
                    if (r_wait == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cke   <= 1'b1;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign lp_ack     = r_ack;
    assign lp_done    = r_done;
    assign busy       = r_busy;
    assign lp_cycles  = r_lp_cycles;
    assign sdram_cke  = r_cke;
    assign sdram_cmd  = r_cmd;
    assign sdram_ba   = '0;
    assign sdram_addr = r_addr;

endmodule

// File: tb/tb_sdram_lowpower_ctrl.sv
// Directed bench for sdram_lowpower_ctrl: per-cycle vector table plus hand sequences
// for reset-in-hold and residency-counter saturation (second instance, CNT_W = 4).
module tb_sdram_lowpower_ctrl;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] AR  = 4'b0001;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        sdram_init = 1'b0;
    logic        lp_req = 1'b0;
    logic        lp_mode = 1'b0;

    logic        lp_ack, lp_done, busy, sdram_cke;
    logic [15:0] lp_cycles;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;

    logic        lp_ack2, lp_done2, busy2, sdram_cke2;
    logic [3:0]  lp_cycles2;
    logic [3:0]  sdram_cmd2;
    logic [1:0]  sdram_ba2;
    logic [11:0] sdram_addr2;

    always #5 sys_clk = ~sys_clk;

    sdram_lowpower_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sdram_init(sdram_init),
        .lp_req(lp_req), .lp_mode(lp_mode), .lp_ack(lp_ack), .lp_done(lp_done),
        .busy(busy), .lp_cycles(lp_cycles), .sdram_cke(sdram_cke),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr)
    );

    sdram_lowpower_ctrl #(.CNT_W(4)) dut_sat (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sdram_init(sdram_init),
        .lp_req(lp_req), .lp_mode(lp_mode), .lp_ack(lp_ack2), .lp_done(lp_done2),
        .busy(busy2), .lp_cycles(lp_cycles2), .sdram_cke(sdram_cke2),
        .sdram_cmd(sdram_cmd2), .sdram_ba(sdram_ba2), .sdram_addr(sdram_addr2)
    );

    typedef struct {
        logic        rst, init, req, mode;
        logic        cke;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic        ack, done, bsy;
        logic [15:0] lpc;
    } vec_t;

    vec_t vecs[$];
    int   exp_lpc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push_idle(input logic rst, input logic init, input logic req);
        vec_t v;
        v.rst = rst; v.init = init; v.req = req; v.mode = 1'b0;
        if (rst) exp_lpc = 0;
        v.cke = 1'b1; v.cmd = NOP; v.addr = 12'h000;
        v.ack = 1'b0; v.done = 1'b0; v.bsy = 1'b0; v.lpc = 16'(exp_lpc);
        vecs.push_back(v);
    endtask

    // One full episode from IDLE; r = cycles lp_req is held, scramble drops
    // sdram_init and flips lp_mode after acceptance, tail keeps lp_req high through DONE.
    task automatic gen_episode(input logic mode, input int r, input bit scramble, input bit tail);
        int jx, nx;
        vec_t v;
        jx = (r + 1 > 7) ? r + 1 : 7;
        nx = mode ? 2 : 8;
        for (int i = 1; i <= jx + nx + 1; i++) begin
            v.rst  = 1'b0;
            v.init = (scramble && i > 1) ? 1'b0 : 1'b1;
            v.req  = (i <= r) || (tail && i >= jx + nx);
            v.mode = (scramble && i > 1) ? ~mode : mode;
            v.cke = 1'b1; v.cmd = NOP; v.addr = 12'h000;
            v.ack = 1'b0; v.done = 1'b0; v.bsy = 1'b1;
            if (i == 1) begin
                v.cmd = PRE; v.addr = 12'h400;
            end else if (i == 2) begin
                v.cmd = NOP;
            end else if (i == 3) begin
                v.cke = 1'b0; v.cmd = mode ? NOP : AR;
            end else if (i < jx) begin
                v.cke = 1'b0; v.ack = 1'b1;
            end else if (i < jx + nx) begin
                exp_lpc = jx - 3;
            end else if (i == jx + nx) begin
                v.done = 1'b1;
            end else begin
                v.bsy = 1'b0;
            end
            v.lpc = 16'(exp_lpc);
            vecs.push_back(v);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [41:0] dut_bus();
        return {sdram_cke, sdram_cmd, sdram_ba, sdram_addr, lp_ack, lp_done, busy,
                lp_cycles, lp_cycles2};
    endfunction

    initial begin
        int cke_low;
        bit seen;
        logic [3:0] lpc2;

        // Reset, idle, init gating, then episodes
        push_idle(1'b1, 1'b0, 1'b0);
        push_idle(1'b1, 1'b1, 1'b1);
        push_idle(1'b0, 1'b1, 1'b0);
        push_idle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) push_idle(1'b0, 1'b0, 1'b1);
        gen_episode(1'b0, 20, 1'b0, 1'b0);   // self-refresh, lp_cycles 18
        gen_episode(1'b1, 20, 1'b0, 1'b0);   // power-down, 2-cycle exit
        gen_episode(1'b0, 1, 1'b0, 1'b0);    // 1-cycle pulse, CKE low exactly 4
        gen_episode(1'b1, 3, 1'b1, 1'b1);    // late init/mode changes, back-to-back
        gen_episode(1'b0, 2, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            sys_rst    = vecs[k].rst;
            sdram_init = vecs[k].init;
            lp_req     = vecs[k].req;
            lp_mode    = vecs[k].mode;
            step();
            lpc2 = (vecs[k].lpc > 16'd15) ? 4'd15 : vecs[k].lpc[3:0];
            check($sformatf("vec%0d", k), 64'(dut_bus()),
                  64'({vecs[k].cke, vecs[k].cmd, 2'b00, vecs[k].addr, vecs[k].ack,
                       vecs[k].done, vecs[k].bsy, vecs[k].lpc, lpc2}));
        end

        // Reset while holding in self-refresh
        sdram_init = 1'b1; lp_req = 1'b1; lp_mode = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("hold_before_rst", 64'({sdram_cke, lp_ack, busy}), 64'(3'b011));
        sys_rst = 1'b1; lp_req = 1'b0;
        step();
        check("rst_in_hold", 64'(dut_bus()),
              64'({1'b1, NOP, 2'b00, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0}));
        sys_rst = 1'b0;
        step();
        check("idle_after_rst", 64'({sdram_cke, sdram_cmd, busy}), 64'({1'b1, NOP, 1'b0}));

        // Long power-down hold: 38 CKE-low cycles, 4-bit counter saturates at 15
        cke_low = 0;
        lp_req = 1'b1; lp_mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!sdram_cke) cke_low++;
        end
        lp_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (!sdram_cke) cke_low++;
            if (lp_done) seen = 1'b1;
        end
        check("sat_done_seen", 64'(seen), 64'(1));
        check("sat_cke_low", 64'(cke_low), 64'(38));
        check("sat_lpc16", 64'(lp_cycles), 64'(38));
        check("sat_lpc4", 64'(lp_cycles2), 64'(15));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
